commit_trace_fifo: RTL
======================

Name: commit_trace_fifo

Overview:
- Capture stage between the dual-issue core's writeback/dbus write observation points and the bench's golden-answer checker.
- Each non-stalled cycle it samples up to three commit events: one data-bus store and two register writebacks.
- It orders them in the checker's canonical order and buffers them in a FIFO.
- Events are presented one per cycle on a valid/ready stream, so comparison logic is decoupled from the dual-issue retire rate.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- ADDR_W, 16, stored memory address width; low 2 bits are forced to zero.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  dbus stall seen one cycle late; when 1, no capture this cycle.
- wb0_rd  in  5  path-0 writeback register; 0 means no event.
- wb0_wdata  in  32  path-0 writeback data.
- wb1_rd  in  5  path-1 writeback register; 0 means no event.
- wb1_wdata  in  32  path-1 writeback data.
- st_we  in  1  store committed (delayed dbus write).
- st_addr  in  ADDR_W  store address.
- st_data  in  32  store data.
- st_path0  in  1  1 = store issued on path 0; 0 = path 1.
- ev_valid  out  1  head event valid.
- ev_ready  in  1  consumer accepts head.
- ev_is_mem  out  1  1 = store event, 0 = register event.
- ev_addr  out  ADDR_W  store address, or register number zero-extended.
- ev_data  out  32  written value.
- ev_cycle  out  32  cycle stamp (see Optional Feature).
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a cycle's events were dropped.

Behaviour:
- Reset (rst=1 at rising edge):
  - pointers and count cleared, so ev_valid=0 and count=0.
  - overflow=0; cycle counter=0.
  - FIFO storage is not cleared; ev_* data outputs are don't-care while ev_valid=0.
  - Reset during backlog discards all entries.
- Capture, when stall=0. Candidates are built in canonical order:
  - st_path0=1: store, then wb0, then wb1.
  - st_path0=0: wb0, then store, then wb1.
  - A candidate is present only if: store needs st_we=1; wbN needs wbN_rd!=0.
  - Present candidates are compacted, giving n in 0..3.
  - st_addr[1:0] is stored as 2'b00.
- Admission is atomic per cycle:
  - If n <= DEPTH - count (count before this edge; a pop in the same cycle is not credited), all n are written at wr_ptr, wr_ptr+1, wr_ptr+2.
  - Otherwise none are written and overflow is set to 1. It stays set until reset.
- Pop: ev_valid = (count != 0); head is at rd_ptr. When ev_valid & ev_ready, rd_ptr advances by 1.
- Count update: count_next = count + admitted_n - pop. Simultaneous push and pop on a non-empty FIFO is legal.
- Pointers wrap modulo DEPTH (natural binary wrap).
- Latency: an event captured at edge k is visible on ev_* after edge k if the FIFO was empty (registered storage, one cycle).
- ev_* outputs come directly from the storage array at rd_ptr; there is no output register.
- stall=1 blocks capture only; popping continues.

Optional Feature:
- Macro: COMMIT_TRACE_CYCLE_STAMP_EN.
- When defined:
  - A 32-bit free-running counter increments every cycle after reset; it wraps at 2^32.
  - Each admitted event stores the counter value of its capture cycle, presented on ev_cycle.
  - All events from one cycle share the same stamp.
- When undefined:
  - No counter and no stamp storage.
  - ev_cycle is tied to 32'h0.

Decomposition:
- Shared package trace_pkg holds:
  - typedef trace_event_t (is_mem, addr, data, optional cycle);
  - constant TRACE_MAX_PER_CYCLE = 3.
- One sub-module, trace_event_pack: combinational ordering and compaction of the three candidates into trace_event_t [2:0] plus n. It is unit-testable on its own.

Test Plan:
- Single register event: after reset, wb0_rd=1, wb0_wdata=32'h0000_1234, st_we=0, wb1_rd=0 for one cycle, ev_ready=1 -> next cycle ev_valid=1, ev_is_mem=0, ev_addr=1, ev_data=32'h1234; the cycle after, ev_valid=0.
- Triple ordering, store on path 1: st_path0=0, st_we=1, st_addr=16'h0013, st_data=32'hDEADBEEF, wb0_rd=2/32'h5, wb1_rd=3/32'h7, ev_ready=0 -> count=3. Then ev_ready=1 pops in order: reg 2 (5), mem 0x0010 (DEADBEEF), reg 3 (7).
- Triple ordering, store on path 0: same stimulus with st_path0=1 -> pop order: mem 0x0010, reg 2, reg 3.
- Stall and zero-rd filtering: stall=1 with all events present -> count stays 0. Then stall=0, wb0_rd=0, wb1_rd=4 -> exactly one event, reg 4.
- Overflow: DEPTH=16, ev_ready=0, five cycles of 3 events -> count=15. Sixth cycle with 2 events -> count stays 15, overflow=1. One pop, then a cycle with 1 event -> count=15, overflow still 1.
- Wrap and reset: stream 40 single events with ev_ready=1 -> all 40 delivered in order with no loss. Assert rst with count=5 -> next cycle count=0, ev_valid=0, overflow=0. With COMMIT_TRACE_CYCLE_STAMP_EN, stamps increase by 1 per capture cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the commit trace capture path
//
// Purpose: event record carried from the ordering/compaction stage into the
//          trace FIFO, plus the per-cycle event limit.
// Optional feature macro: COMMIT_TRACE_CYCLE_STAMP_EN adds the cycle field.
package trace_pkg;

  // Store + two writebacks per retire cycle.
  localparam int TRACE_MAX_PER_CYCLE = 3;

  // The record carries a full-width address; the FIFO keeps only ADDR_W bits.
  localparam int TRACE_ADDR_MAX_W = 32;

  typedef struct packed {
    logic                        is_mem;
    logic [TRACE_ADDR_MAX_W-1:0] addr;
    logic [31:0]                 data;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [31:0]                 cycle;
`endif
  } trace_event_t;

endpackage

// File: rtl/trace_event_pack.sv
// rtl/trace_event_pack.sv - canonical ordering and compaction of one cycle's commit events
//
// Purpose: builds the three candidates (store, wb0, wb1) in checker order,
//          drops absent ones and packs the survivors into slots 0..n-1.
// Ports:
//   wb0_rd/wb0_wdata, wb1_rd/wb1_wdata : register writebacks (rd==0 -> absent)
//   st_we/st_addr/st_data/st_path0     : committed store and its issue path
//   stamp                              : capture-cycle stamp (COMMIT_TRACE_CYCLE_STAMP_EN only)
//   ev                                 : compacted events, slot 0 first
//   n                                  : number of valid slots (0..3)
// Optional feature macro: COMMIT_TRACE_CYCLE_STAMP_EN.
module trace_event_pack
  import trace_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [4:0]                                 wb0_rd,
  input  logic [31:0]                                wb0_wdata,
  input  logic [4:0]                                 wb1_rd,
  input  logic [31:0]                                wb1_wdata,
  input  logic                                       st_we,
  input  logic [ADDR_W-1:0]                          st_addr,
  input  logic [31:0]                                st_data,
  input  logic                                       st_path0,
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  input  logic [31:0]                                stamp,
`endif
  output trace_event_t [TRACE_MAX_PER_CYCLE-1:0]     ev,
  output logic [1:0]                                 n
);

  trace_event_t                           ev_st, ev_w0, ev_w1;
  trace_event_t [TRACE_MAX_PER_CYCLE-1:0] cand;
  logic [TRACE_MAX_PER_CYCLE-1:0]         pres;

  always_comb begin
    ev_st        = '0;
    ev_st.is_mem = 1'b1;
    // Stores are word-granular in the checker: low address bits forced to zero.
    ev_st.addr   = TRACE_ADDR_MAX_W'(st_addr & ~ADDR_W'(3));
    ev_st.data   = st_data;

    ev_w0        = '0;
    ev_w0.addr   = TRACE_ADDR_MAX_W'(wb0_rd);
    ev_w0.data   = wb0_wdata;

    ev_w1        = '0;
    ev_w1.addr   = TRACE_ADDR_MAX_W'(wb1_rd);
    ev_w1.data   = wb1_wdata;

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    ev_st.cycle  = stamp;
    ev_w0.cycle  = stamp;
    ev_w1.cycle  = stamp;
`endif
  end

  // A path-0 store retires ahead of wb0; a path-1 store sits between wb0 and wb1.
  always_comb begin
    if (st_path0) begin
      cand[0] = ev_st;
      cand[1] = ev_w0;
      pres[0] = st_we;
      pres[1] = (wb0_rd != 5'd0);
    end else begin
      cand[0] = ev_w0;
      cand[1] = ev_st;
      pres[0] = (wb0_rd != 5'd0);
      pres[1] = st_we;
    end
    cand[2] = ev_w1;
    pres[2] = (wb1_rd != 5'd0);
  end

  always_comb begin
    int slot;
    ev   = '0;
    slot = 0;
    for (int i = 0; i < TRACE_MAX_PER_CYCLE; i++) begin
      if (pres[i]) begin
        ev[slot] = cand[i];
        slot     = slot + 1;
      end
    end
    n = 2'(slot);
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - commit event capture FIFO feeding the golden-answer checker
//
// Purpose: samples up to three commit events per non-stalled cycle, admits
//          them atomically into a FIFO and streams them out one per cycle.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall                    : blocks capture for this cycle (pop unaffected)
//   wb0_*, wb1_*, st_*       : commit observation inputs
//   ev_valid/ev_ready        : output handshake, head of FIFO
//   ev_is_mem/addr/data/cycle: head event fields (ev_cycle is 0 unless stamped)
//   count                    : occupancy
//   overflow                 : sticky, a whole cycle of events was dropped
// Optional feature macro: COMMIT_TRACE_CYCLE_STAMP_EN (per-event cycle stamp).
module commit_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,  // power of two, >= 4
  parameter int ADDR_W = 16   // 3..32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [4:0]                wb0_rd,
  input  logic [31:0]               wb0_wdata,
  input  logic [4:0]                wb1_rd,
  input  logic [31:0]               wb1_wdata,
  input  logic                      st_we,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [31:0]               st_data,
  input  logic                      st_path0,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic                      ev_is_mem,
  output logic [ADDR_W-1:0]         ev_addr,
  output logic [31:0]               ev_data,
  output logic [31:0]               ev_cycle,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  trace_event_t [TRACE_MAX_PER_CYCLE-1:0] ev_pk;
  logic [1:0]                             n_cand;

  logic              mem_is_mem [DEPTH];
  logic [ADDR_W-1:0] mem_addr   [DEPTH];
  logic [31:0]       mem_data   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic [CNT_W-1:0]  free_slots;
  logic              fits;
  logic [1:0]        admit_n;
  logic              drop;
  logic              pop;
  logic [PTR_W-1:0]  slot_idx [TRACE_MAX_PER_CYCLE];

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  logic [31:0]       cycle_q;
  logic [31:0]       mem_cycle [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) cycle_q <= 32'd0;
    else     cycle_q <= cycle_q + 32'd1;
  end
`endif

  trace_event_pack #(.ADDR_W(ADDR_W)) u_pack (
    .wb0_rd    (wb0_rd),
    .wb0_wdata (wb0_wdata),
    .wb1_rd    (wb1_rd),
    .wb1_wdata (wb1_wdata),
    .st_we     (st_we),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_path0  (st_path0),
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    .stamp     (cycle_q),
`endif
    .ev        (ev_pk),
    .n         (n_cand)
  );

  // Free space uses pre-edge occupancy; a same-cycle pop is deliberately not credited.
  always_comb begin
    free_slots = CNT_W'(DEPTH) - count_q;
    fits       = (CNT_W'(n_cand) <= free_slots);
    admit_n    = (!stall && fits) ? n_cand : 2'd0;
    drop       = !stall && !fits;
    pop        = ev_valid && ev_ready;
  end

  always_comb begin
    for (int i = 0; i < TRACE_MAX_PER_CYCLE; i++) begin
      slot_idx[i] = wr_ptr + PTR_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(admit_n);
      rd_ptr  <= rd_ptr + PTR_W'(pop);
      count_q <= count_q + CNT_W'(admit_n) - CNT_W'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage is intentionally not reset; ev_valid gates its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TRACE_MAX_PER_CYCLE; i++) begin
      if (2'(i) < admit_n) begin
        mem_is_mem[slot_idx[i]] <= ev_pk[i].is_mem;
        mem_addr[slot_idx[i]]   <= ev_pk[i].addr[ADDR_W-1:0];
        mem_data[slot_idx[i]]   <= ev_pk[i].data;
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
        mem_cycle[slot_idx[i]]  <= ev_pk[i].cycle;
`endif
      end
    end
  end

  // Address bits above ADDR_W are always zero from the packer.
  if (ADDR_W < TRACE_ADDR_MAX_W) begin : g_addr_hi
    logic addr_hi_unused;
    always_comb begin
      addr_hi_unused = 1'b0;
      for (int i = 0; i < TRACE_MAX_PER_CYCLE; i++) begin
        addr_hi_unused = addr_hi_unused ^ (^ev_pk[i].addr[TRACE_ADDR_MAX_W-1:ADDR_W]);
      end
    end
  end

  assign ev_valid  = (count_q != '0);
  assign ev_is_mem = mem_is_mem[rd_ptr];
  assign ev_addr   = mem_addr[rd_ptr];
  assign ev_data   = mem_data[rd_ptr];
`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
  assign ev_cycle  = mem_cycle[rd_ptr];
`else
  assign ev_cycle  = 32'h0;
`endif
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
